kpg_serial_subtractor: RTL and testbench

- Multi-cycle 64-bit subtractor computing diff = a - b - bin.
- Built on the same kill/propagate/generate carry encoding as the team's 64-bit CLA datapath, with each KPG symbol stored as an 8-bit ASCII code ("k"=0x6B, "p"=0x70, "g"=0x67).
- Processes one CHUNK-bit slice per clock and carries the resolved KPG state between slices in a register.
- Sits beside the combinational adder as the area-cheap subtract path for the Wallace/CLA arithmetic unit; valid/ready handshake on both sides.

---
 rtl/kpg_serial_subtractor.sv | 171 +++++++++++++++++
 tb/tb_kpg_serial_subtractor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/kpg_serial_subtractor.sv
// Serial 64-bit subtractor: diff = a - b - bin, resolved CHUNK bits per clock with KPG carry symbols.
// Latency: out_valid rises WIDTH/CHUNK edges after the accept edge; one op per WIDTH/CHUNK+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, inputs ignored meanwhile.
module kpg_serial_subtractor #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic [7:0]       xout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  // KPG symbols kept as ASCII so they read directly in waveforms and match the CLA datapath.
  localparam logic [7:0] SYM_K = 8'h6B;
  localparam logic [7:0] SYM_P = 8'h70;
  localparam logic [7:0] SYM_G = 8'h67;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  nb_q, nb_d;      // subtrahend stored already inverted
  logic [7:0]        carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;
  logic [7:0]        xout_q, xout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [CHUNK-1:0]  a_sl;
  logic [CHUNK-1:0]  nb_sl;
  logic [CHUNK-1:0]  sl_diff;
  logic [7:0]        sl_cout;

  // Per-bit generate/kill/propagate classification of one operand bit pair.
  function automatic logic [7:0] kpg_sym(input logic x, input logic y);
    logic [7:0] s;
    if (x && y)        s = SYM_G;
    else if (!x && !y) s = SYM_K;
    else               s = SYM_P;
    return s;
  endfunction

  // Select the active slice and ripple the KPG prefix across it from the incoming carry symbol.
  always_comb begin : slice_comb
    logic [7:0] c;
    logic [7:0] s;
    a_sl  = '0;
    nb_sl = '0;
    for (int j = 0; j < NCHUNK; j++) begin
      if (idx_q == IDXW'(j)) begin
        a_sl  = a_q[j*CHUNK +: CHUNK];
        nb_sl = nb_q[j*CHUNK +: CHUNK];
      end
    end
    c       = carry_q;
    sl_diff = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sl_diff[i] = a_sl[i] ^ nb_sl[i] ^ (c == SYM_G);
      s = kpg_sym(a_sl[i], nb_sl[i]);
      // "p" passes the incoming symbol through; "k"/"g" resolve it, so c is never "p".
      if (s != SYM_P) c = s;
    end
    sl_cout = c;
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    nb_d    = nb_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    xout_d  = xout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          nb_d    = ~b;
          // Borrow-in of 0 means a carry-in of 1 into a + ~b.
          carry_d = bin ? SYM_K : SYM_G;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = sl_cout;
        for (int j = 0; j < NCHUNK; j++) begin
          if (idx_q == IDXW'(j)) diff_d[j*CHUNK +: CHUNK] = sl_diff;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          xout_d  = sl_cout;
          bout_d  = (sl_cout == SYM_K);
          // Operand signs differ when a's MSB equals the inverted b's MSB.
          ovf_d   = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (diff_d == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      nb_q    <= '0;
      carry_q <= SYM_K;
      idx_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      xout_q  <= SYM_K;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      xout_q  <= xout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign xout      = xout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // A propagate symbol must never be stored as a resolved carry.
  assert property (@(posedge clk) disable iff (!rst_n) (carry_q != SYM_P) && (xout_q != SYM_P));

endmodule

// File: tb/tb_kpg_serial_subtractor.sv
module tb_kpg_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout;
  logic [7:0]  xout;
  logic        ovf;
  logic        zero;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  kpg_serial_subtractor #(.WIDTH(64), .CHUNK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .xout      (xout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present operands at a falling edge and hold until the accept edge.
  task automatic start_op(input logic [63:0] ta, input logic [63:0] tb_, input logic tbin);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (w >= 30) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble operands after acceptance; the result must not change.
    in_valid = 1'b0;
    a = 64'hDEAD_BEEF_CAFE_F00D; b = 64'h0123_4567_89AB_CDEF; bin = ~tbin;
  endtask

  // Count rising edges after the accept edge until out_valid is seen.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd8);
  endtask

  task automatic check_res(input string tag, input logic [63:0] ed, input logic eb,
                           input logic [7:0] ex, input logic eo, input logic ez);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, 64'(bout), 64'(eb));
    chk({tag, "_xout"}, 64'(xout), 64'(ex));
    chk({tag, "_ovf"},  64'(ovf),  64'(eo));
    chk({tag, "_zero"}, 64'(zero), 64'(ez));
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_,
                        input logic tbin, input logic [63:0] ed, input logic eb,
                        input logic [7:0] ex, input logic eo, input logic ez);
    start_op(ta, tb_, tbin);
    wait_done(tag);
    check_res(tag, ed, eb, ex, eo, ez);
    release_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bad;
    logic [63:0] held;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #12;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_diff",      diff,           64'd0);
    chk("rst_xout",      64'(xout),      64'h6B);
    chk("rst_bout",      64'(bout),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("sub5_3",  64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 8'h67, 1'b0, 1'b0);
    run_op("sub0_1",  64'd0, 64'd1, 1'b0, ALL1,  1'b1, 8'h6B, 1'b0, 1'b0);
    run_op("ovf_neg", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 8'h67, 1'b1, 1'b0);
    run_op("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, ALL1, 1'b0,
           64'h8000_0000_0000_0000, 1'b1, 8'h6B, 1'b1, 1'b0);
    run_op("eq_b0",   64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0,
           64'd0, 1'b0, 8'h67, 1'b0, 1'b1);
    run_op("eq_b1",   64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
           ALL1, 1'b1, 8'h6B, 1'b0, 1'b0);
    run_op("chain",   64'h0000_0001_0000_0000, 64'd1, 1'b0,
           64'h0000_0000_FFFF_FFFF, 1'b0, 8'h67, 1'b0, 1'b0);

    // Hold the result with out_ready low while new operands are offered.
    start_op(64'd100, 64'd58, 1'b0);
    wait_done("hold");
    held = diff;
    chk("hold_diff0", held, 64'd42);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = i[0];
      a = 64'(i) * 64'h1111; b = 64'(i); bin = i[1];
      @(posedge clk);
      #1;
      if (diff !== held || !out_valid || in_ready || xout !== 8'h67) bad++;
    end
    chk("hold_bad_cycles", 64'(bad), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("rel_out_valid", 64'(out_valid), 64'd0);
    chk("rel_in_ready",  64'(in_ready),  64'd1);
    run_op("after_rel", 64'd7, 64'd2, 1'b0, 64'd5, 1'b0, 8'h67, 1'b0, 1'b0);

    // Asynchronous reset while in RUN chunk 3.
    start_op(64'h5555_5555_5555_5555, 64'h1111_1111_1111_1111, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_diff",      diff,           64'd0);
    chk("arst_bout",      64'(bout),      64'd0);
    chk("arst_xout",      64'(xout),      64'h6B);
    chk("arst_ovf",       64'(ovf),       64'd0);
    chk("arst_zero",      64'(zero),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) bad++;
    end
    chk("arst_no_pulse", 64'(bad), 64'd0);
    run_op("post_rst", 64'd10, 64'd4, 1'b0, 64'd6, 1'b0, 8'h67, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
